line_mem_responder: RTL

- Responder end of the core's 256-bit line memory interface: accepts line read/write requests from the core and services them from internal line storage.
- Services each request after a configurable multi-cycle latency, then reports completion with a one-cycle done pulse.
- Sits where the single-cycle data RAM sits at top level, so the core's memory stage can be exercised against realistic latency.
- Adds busy/done/err handshake outputs alongside the existing request signals.

---
 rtl/line_mem_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - 256-bit line memory responder with configurable read/write latency
module line_mem_responder #(
    parameter int LINE_BITS   = 256,
    parameter int DEPTH_LINES = 64,
    parameter int READ_LAT    = 4,
    parameter int WRITE_LAT   = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 read_op,
    input  logic                 write_op,
    input  logic [31:0]          addr,
    input  logic [LINE_BITS-1:0] data_i,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W  = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_BITS-1:0] data_q;
    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    logic [IDX_W-1:0] idx_in;
    logic             out_of_range;
    logic             mem_we;
    logic             unused_addr_bits;

    assign idx_in           = addr[5 +: IDX_W];
    assign out_of_range     = |addr[31:5+IDX_W];
    assign unused_addr_bits = ^addr[4:0];
    // The commit edge is the one that also returns to IDLE; reset at that edge suppresses it.
    assign mem_we           = (state == WR_WAIT) && (cnt == '0) && !RST;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx_q] <= data_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            data_q <= '0;
            data_o <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_op || write_op) begin
                        if ((read_op && write_op) || out_of_range) begin
                            err <= 1'b1;
                        end else if (read_op) begin
                            idx_q <= idx_in;
                            cnt   <= CNT_W'(READ_LAT - 1);
                            state <= RD_WAIT;
                            busy  <= 1'b1;
                        end else begin
                            idx_q  <= idx_in;
                            data_q <= data_i;
                            cnt    <= CNT_W'(WRITE_LAT - 1);
                            state  <= WR_WAIT;
                            busy   <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        data_o <= mem[idx_q];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
